updown_ctrl: RTL and testbench
==============================

UPDOWN_CTRL -- requirements
Module: updown_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a button level change (range 2..65535).
REQ-002 Parameter: REPEAT_DELAY, 1000, cycles a button is held before the first auto-repeat pulse (used only with HOLD_REPEAT_EN).
REQ-003 Parameter: REPEAT_PERIOD, 250, cycles between later auto-repeat pulses (used only with HOLD_REPEAT_EN).
REQ-004 Port: clk  input  1  single clock; all state on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: btn_up  input  1  raw asynchronous up pushbutton, active-high.
REQ-007 Port: btn_down  input  1  raw asynchronous down pushbutton, active-high.
REQ-008 Port: D  input  4  next-count value from the external add/subtract stage.
REQ-009 Port: A  output  2  registered command to the add/subtract stage: 00 hold, 01 up, 10 down; 11 never driven.
REQ-010 Port: Q  output  4  registered count, fed back to the add/subtract stage.
REQ-011 Port: wrap  output  1  one-cycle pulse when a command wraps the count (15 up to 0, or 0 down to 15).

Function
REQ-012 Each button passes through a 2-flop synchronizer, then a debouncer; the debounced level changes in the cycle after the synchronized input has held the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 The debouncer restarts its stability count on any synchronized sample equal to the current debounced level.
REQ-014 A debounced rising edge on exactly one button sets A to 01 (up) or 10 (down) for exactly one cycle, in the cycle after the edge; A is 00 otherwise.
REQ-015 Both debounced rising edges in the same cycle give A = 00 (no command); no command is queued.
REQ-016 A rising edge on one button while the other is debounced-high gives A = 00 (conflict suppression).
REQ-017 Q loads D on every clock edge; Q changes one cycle after an A pulse, and holds because the external stage returns D = Q when A = 00.
REQ-018 Wrap rule: wrap is high in the same cycle Q loads D whenever A = 01 and Q = 15, or A = 10 and Q = 0.
REQ-019 Debounced falling edges produce no command.
REQ-020 Total latency from a stable raw press to the Q update is 2 + DEBOUNCE_CYCLES + 2 cycles.

Reset
REQ-021 rst_n low immediately clears A = 00, Q = 0, wrap = 0, synchronizers, debounced levels, and all counters, with no clock needed.
REQ-022 Assertion mid-press discards the press; after release of rst_n, a still-held button is a new press only after the full debounce interval.
REQ-023 rst_n release is synchronized externally; the block needs no internal reset synchronizer.

Configuration
REQ-024 With HOLD_REPEAT_EN defined, a single debounced-held button (other button low) emits its command pulse REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles until release; release or a press of the other button stops repetition immediately.
REQ-025 Without HOLD_REPEAT_EN, repeat counters and parameters have no logic, and holding a button yields exactly one command.

Structure
REQ-026 A shared package holds the command encodings CMD_HOLD = 00, CMD_UP = 01, CMD_DOWN = 10, and COUNT_W = 4.
REQ-027 One sub-module, btn_debounce (synchronizer plus debouncer, parameter DEBOUNCE_CYCLES, outputs level and rise pulse), is instantiated once per button.

Verification
REQ-028 The bench models the external stage as D = Q+1 mod 16 for A = 01, Q-1 mod 16 for A = 10, and Q otherwise, and uses DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.
REQ-029 Reset, then hold btn_up high 20 cycles -> one A = 01 pulse exactly 7 cycles after the raw edge; Q goes 0 -> 1 at cycle 8.
REQ-030 Toggle btn_up every 2 cycles for 20 cycles (bounce), then hold low -> A stays 00 and Q stays 0.
REQ-031 From Q = 15, a btn_up press -> Q = 0 with wrap high for one cycle; from Q = 0, a btn_down press -> Q = 15 with wrap high.
REQ-032 Both buttons rise in the same cycle -> A = 00 throughout and Q unchanged; btn_down pressed while btn_up is held -> no command.
REQ-033 With HOLD_REPEAT_EN, hold btn_down for 30 cycles from Q = 5 -> pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 after the first pulse, then stop on release; without it, Q = 4 only.
REQ-034 Drive rst_n low 3 cycles into a debounce window -> Q = 0 and A = 00 at once; after release, a held button gives one pulse 7 cycles later.

Source files
------------

// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down pushbutton counter controller:
// command encodings, count width and the wrap-detection helper.
package updown_ctrl_pkg;

    localparam int COUNT_W = 4;

    // Debounce counter width covers the full DEBOUNCE_CYCLES range (up to 65535).
    localparam int DB_CNT_W = 16;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_UP   = 2'b01,
        CMD_DOWN = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'b00,
        RPT_UP   = 2'b01,
        RPT_DOWN = 2'b10
    } rpt_state_e;

    function automatic logic is_wrap(input cmd_e cmd, input logic [COUNT_W-1:0] q);
        return ((cmd == CMD_UP) && (q == '1)) || ((cmd == CMD_DOWN) && (q == '0));
    endfunction

endpackage

// File: rtl/updown_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for one raw pushbutton.
// Provides the debounced level and a one-cycle pulse aligned with its rise.
module btn_debounce
    import updown_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                level_q;
    logic                level_d;
    logic                rise_q;
    logic                rise_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // The count tracks consecutive samples differing from the accepted level;
    // any agreeing sample restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/updown_ctrl.sv
// Up/down pushbutton controller driving an external add/subtract stage.
// Optional hold-to-repeat is enabled by defining HOLD_REPEAT_EN.
module updown_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [COUNT_W-1:0] D,
    output logic [1:0]         A,
    output logic [COUNT_W-1:0] Q,
    output logic               wrap
);

    logic up_level;
    logic up_rise;
    logic dn_level;
    logic dn_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_up),
        .level_o(up_level),
        .rise_o (up_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_dn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_down),
        .level_o(dn_level),
        .rise_o (dn_rise)
    );

    cmd_e               press_cmd;
    cmd_e               cmd_d;
    cmd_e               cmd_q;
    logic [COUNT_W-1:0] q_q;
    logic               wrap_q;

    // The other level is already high when both rise together, so checking
    // it covers both simultaneous presses and conflicts with a held button.
    always_comb begin
        press_cmd = CMD_HOLD;
        if (up_rise && !dn_level) begin
            press_cmd = CMD_UP;
        end else if (dn_rise && !up_level) begin
            press_cmd = CMD_DOWN;
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_d;
    logic             hold_up;
    logic             hold_dn;

    assign hold_up = up_level & ~dn_level;
    assign hold_dn = dn_level & ~up_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RPT_IDLE;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
        end
    end

    // rpt_q counts down to the next repeat; it reaches zero exactly on the
    // edge that must register the repeated command.
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        unique case (state_q)
            RPT_IDLE: begin
                if (press_cmd == CMD_UP) begin
                    state_d = RPT_UP;
                    rpt_d   = RPT_FIRST;
                end else if (press_cmd == CMD_DOWN) begin
                    state_d = RPT_DOWN;
                    rpt_d   = RPT_FIRST;
                end
            end
            RPT_UP: begin
                if (!hold_up) begin
                    state_d = RPT_IDLE;
                end else if (rpt_q == '0) begin
                    rpt_d = RPT_NEXT;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
            RPT_DOWN: begin
                if (!hold_dn) begin
                    state_d = RPT_IDLE;
                end else if (rpt_q == '0) begin
                    rpt_d = RPT_NEXT;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    always_comb begin
        cmd_d = press_cmd;
        if ((state_q == RPT_UP) && hold_up && (rpt_q == '0)) begin
            cmd_d = CMD_UP;
        end else if ((state_q == RPT_DOWN) && hold_dn && (rpt_q == '0)) begin
            cmd_d = CMD_DOWN;
        end
    end
`else
    always_comb begin
        cmd_d = press_cmd;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CMD_HOLD;
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            q_q    <= D;
            wrap_q <= is_wrap(cmd_q, q_q);
        end
    end

    assign A    = cmd_q;
    assign Q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl with a behavioural add/subtract stage on D.
// Cycle vectors for press/bounce, hand sequences for wrap, conflict, repeat, reset.
module tb_updown_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] D;
    logic [1:0] A;
    logic [3:0] Q;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    int cyc;
    int n_up;
    int n_dn;
    int n_ill = 0;
    int n_wrap;
    int first_a;
    int first_wrap;
    int offs[$];

    typedef struct {
        logic       rst;
        logic       up;
        logic       dn;
        logic [1:0] a;
        logic [3:0] q;
        logic       w;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    updown_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .D       (D),
        .A       (A),
        .Q       (Q),
        .wrap    (wrap)
    );

    // External add/subtract stage.
    always_comb begin
        case (A)
            2'b01:   D = Q + 4'd1;
            2'b10:   D = Q - 4'd1;
            default: D = Q;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear();
        cyc        = 0;
        n_up       = 0;
        n_dn       = 0;
        n_wrap     = 0;
        first_a    = -1;
        first_wrap = -1;
        offs.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (A == 2'b01 || A == 2'b10) begin
            if (A == 2'b01) n_up++;
            else n_dn++;
            if (first_a < 0) first_a = cyc;
            offs.push_back(cyc);
        end
        if (A == 2'b11) n_ill++;
        if (wrap) begin
            n_wrap++;
            if (first_wrap < 0) first_wrap = cyc;
        end
    endtask

    task automatic do_reset();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic up, input logic dn, input int hold, input int idle);
        clear();
        btn_up   = up;
        btn_down = dn;
        repeat (hold) tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (idle) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_offs[8];
        exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28};

        // Single held press: pulse 7 cycles after the raw edge, Q=1 from cycle 8.
        for (int k = 1; k <= 2; k++) vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0});
        for (int k = 1; k <= 20; k++)
            vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, (k == 7) ? 2'b01 : 2'b00, (k >= 8) ? 4'd1 : 4'd0, 1'b0});
        for (int k = 1; k <= 10; k++) vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0});
        // Bounce: two cycles high, two low, never stable long enough.
        for (int k = 1; k <= 2; k++) vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0});
        for (int j = 0; j < 20; j++)
            vecs.push_back(vec_t'{1'b1, ((j / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 2'b00, 4'd0, 1'b0});
        for (int k = 1; k <= 10; k++) vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0});

        clear();
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst;
            btn_up   = vecs[i].up;
            btn_down = vecs[i].dn;
            tick();
            check($sformatf("vec%0d.A", i), int'(A), int'(vecs[i].a));
            check($sformatf("vec%0d.Q", i), int'(Q), int'(vecs[i].q));
            check($sformatf("vec%0d.wrap", i), int'(wrap), int'(vecs[i].w));
        end

        // Down wrap from 0, then up wrap from 15, then a plain increment.
        do_reset();
        press(1'b0, 1'b1, 10, 12);
        check("wrapdn.n_dn", n_dn, 1);
        check("wrapdn.n_up", n_up, 0);
        check("wrapdn.first_a", first_a, 7);
        check("wrapdn.Q", int'(Q), 15);
        check("wrapdn.n_wrap", n_wrap, 1);
        check("wrapdn.wrap_cyc", first_wrap, 8);
        press(1'b1, 1'b0, 10, 12);
        check("wrapup.n_up", n_up, 1);
        check("wrapup.Q", int'(Q), 0);
        check("wrapup.n_wrap", n_wrap, 1);
        check("wrapup.wrap_cyc", first_wrap, 8);
        press(1'b1, 1'b0, 10, 12);
        check("inc.Q", int'(Q), 1);
        check("inc.n_wrap", n_wrap, 0);

        // Simultaneous rise: no command.
        press(1'b1, 1'b1, 10, 12);
        check("both.n_up", n_up, 0);
        check("both.n_dn", n_dn, 0);
        check("both.Q", int'(Q), 1);

        // Down pressed while up is held: only the up press counts.
        clear();
        btn_up = 1'b1;
        repeat (10) tick();
        btn_down = 1'b1;
        repeat (10) tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (12) tick();
        check("conflict.n_up", n_up, 1);
        check("conflict.n_dn", n_dn, 0);
        check("conflict.Q", int'(Q), 2);

        // Hold-repeat: Q=5, then hold down 30 cycles.
        do_reset();
        for (int p = 0; p < 5; p++) press(1'b1, 1'b0, 8, 8);
        check("rpt.preload_Q", int'(Q), 5);
        press(1'b0, 1'b1, 30, 15);
        check("rpt.first_a", first_a, 7);
`ifdef HOLD_REPEAT_EN
        check("rpt.n_dn", n_dn, 8);
        for (int i = 0; i < offs.size() && i < 8; i++)
            check($sformatf("rpt.off%0d", i), offs[i] - first_a, exp_offs[i]);
        check("rpt.Q", int'(Q), 13);
`else
        check("rpt.n_dn", n_dn, 1);
        check("rpt.Q", int'(Q), 4);
`endif

        // Reset three cycles into a debounce window.
        do_reset();
        press(1'b1, 1'b0, 8, 8);
        check("rstmid.pre_Q", int'(Q), 1);
        clear();
        btn_up = 1'b1;
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid.Q_async", int'(Q), 0);
        check("rstmid.A_async", int'(A), 0);
        check("rstmid.wrap_async", int'(wrap), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear();
        repeat (15) tick();
        check("rstmid.n_up", n_up, 1);
        check("rstmid.first_a", first_a, 7);
        check("rstmid.Q", int'(Q), 1);
        btn_up = 1'b0;
        repeat (12) tick();

        // Reset while a command is on A clears it without a clock edge.
        clear();
        btn_up = 1'b1;
        repeat (7) tick();
        check("rstcmd.A_before", int'(A), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstcmd.A_async", int'(A), 0);
        check("rstcmd.Q_async", int'(Q), 0);
        btn_up = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        check("never_A11", n_ill, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
